// File: rtl/system_consts.sv
// rtl/system_consts.sv - shared constants and state types for the SDRAM client arbiter
package system_consts;

    localparam int          ADDR_W_DEFAULT   = 25;
    localparam logic [31:0] SCN_BASE_DEFAULT = 32'h0040_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_CMD,
        ST_CPU_WAIT,
        ST_DONE_CPU,
        ST_SCN_CMD,
        ST_SCN_W0,
        ST_SCN_W1,
        ST_DONE_SCN
    } arb_state_t;

    typedef enum logic {
        GRANT_CPU,
        GRANT_SCN
    } grant_t;

endpackage

// File: rtl/toggle_chan.sv
// rtl/toggle_chan.sv - toggle-handshake channel: pending detect, ack register, q capture
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req            client toggle request
//   done           pulse: flip ack, completing the current service
//   lane_we        per-16-bit-lane capture enable for q
//   lane_data      word written into the enabled lane(s)
//   pend           req != ack
//   ack            toggle acknowledge back to the client
//   q              captured read data, held until the next capture
module toggle_chan #(
    parameter int LANES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  done,
    input  logic [LANES-1:0]      lane_we,
    input  logic [15:0]           lane_data,
    output logic                  pend,
    output logic                  ack,
    output logic [16*LANES-1:0]   q
);

    assign pend = req ^ ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack <= 1'b0;
            q   <= '0;
        end else begin
            if (done) begin
                ack <= ~ack;
            end
            for (int i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    q[16*i +: 16] <= lane_data;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_client_arbiter.sv
// rtl/sdram_client_arbiter.sv - round-robin arbiter of CPU and SCN toggle channels onto one SDRAM command port
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cpu_addr/data/be/rw/req, cpu_ack   CPU channel (byte address, 16-bit read/write)
//   cpu_q                              CPU read data
//   scn_addr/req, scn_ack, scn_q       SCN tile ROM channel (32-bit read as two-word burst)
//   ram_cmd, ram_cmd_rdy               command valid / accept
//   ram_addr/we/burst2/be/wdata        command fields, stable while ram_cmd=1
//   ram_rdata, ram_rvalid, ram_wdone   controller responses
module sdram_client_arbiter
    import system_consts::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [31:0] SCN_BASE = SCN_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cpu_addr,
    input  logic [15:0]       cpu_data,
    input  logic [1:0]        cpu_be,
    input  logic              cpu_rw,
    input  logic              cpu_req,
    output logic              cpu_ack,
    output logic [15:0]       cpu_q,
    input  logic [31:0]       scn_addr,
    input  logic              scn_req,
    output logic              scn_ack,
    output logic [31:0]       scn_q,
    output logic              ram_cmd,
    input  logic              ram_cmd_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_burst2,
    output logic [1:0]        ram_be,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              ram_rvalid,
    input  logic              ram_wdone
);

    arb_state_t state, state_next;
    grant_t     last_grant;

    logic       cpu_pend, scn_pend;
    logic       cpu_done, scn_done;
    logic [0:0] cpu_cap;
    logic [1:0] scn_cap;
    logic       latch_cpu, latch_scn;

    // 32-bit wrap-around add; bits above the controller address range drop out.
    logic [31:0] scn_byte_addr;
    assign scn_byte_addr = scn_addr + SCN_BASE;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[0], cpu_addr[31:ADDR_W+1],
                                scn_byte_addr[1:0], scn_byte_addr[31:ADDR_W+1]};

    toggle_chan #(.LANES(1)) u_cpu_chan (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (cpu_req),
        .done      (cpu_done),
        .lane_we   (cpu_cap),
        .lane_data (ram_rdata),
        .pend      (cpu_pend),
        .ack       (cpu_ack),
        .q         (cpu_q)
    );

    // Lane 1 is scn_q[31:16] (word at A), lane 0 is scn_q[15:0] (word at A+2).
    toggle_chan #(.LANES(2)) u_scn_chan (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (scn_req),
        .done      (scn_done),
        .lane_we   (scn_cap),
        .lane_data (ram_rdata),
        .pend      (scn_pend),
        .ack       (scn_ack),
        .q         (scn_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_SCN;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_burst2 <= 1'b0;
            ram_be     <= 2'b00;
            ram_wdata  <= 16'h0000;
        end else begin
            state <= state_next;
            if (state == ST_DONE_CPU) begin
                last_grant <= GRANT_CPU;
            end
            if (state == ST_DONE_SCN) begin
                last_grant <= GRANT_SCN;
            end
            if (latch_cpu) begin
                ram_addr   <= cpu_addr[ADDR_W:1];
                ram_we     <= ~cpu_rw;
                ram_be     <= cpu_rw ? 2'b11 : cpu_be;
                ram_wdata  <= cpu_data;
                ram_burst2 <= 1'b0;
            end
            if (latch_scn) begin
                ram_addr   <= {scn_byte_addr[ADDR_W:2], 1'b0};
                ram_we     <= 1'b0;
                ram_be     <= 2'b11;
                ram_wdata  <= 16'h0000;
                ram_burst2 <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        ram_cmd    = 1'b0;
        latch_cpu  = 1'b0;
        latch_scn  = 1'b0;
        cpu_done   = 1'b0;
        scn_done   = 1'b0;
        cpu_cap    = 1'b0;
        scn_cap    = 2'b00;
        case (state)
            ST_IDLE: begin
                // On a tie the channel that was not served last wins.
                if (cpu_pend && (!scn_pend || last_grant == GRANT_SCN)) begin
                    state_next = ST_CPU_CMD;
                    latch_cpu  = 1'b1;
                end else if (scn_pend) begin
                    state_next = ST_SCN_CMD;
                    latch_scn  = 1'b1;
                end
            end
            ST_CPU_CMD: begin
                ram_cmd = 1'b1;
                if (ram_cmd_rdy) begin
                    state_next = ST_CPU_WAIT;
                end
            end
            ST_CPU_WAIT: begin
                // ram_we still holds the latched direction of this command.
                if (!ram_we && ram_rvalid) begin
                    cpu_cap    = 1'b1;
                    state_next = ST_DONE_CPU;
                end else if (ram_we && ram_wdone) begin
                    state_next = ST_DONE_CPU;
                end
            end
            ST_DONE_CPU: begin
                cpu_done   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_SCN_CMD: begin
                ram_cmd = 1'b1;
                if (ram_cmd_rdy) begin
                    state_next = ST_SCN_W0;
                end
            end
            ST_SCN_W0: begin
                if (ram_rvalid) begin
                    scn_cap    = 2'b10;
                    state_next = ST_SCN_W1;
                end
            end
            ST_SCN_W1: begin
                if (ram_rvalid) begin
                    scn_cap    = 2'b01;
                    state_next = ST_DONE_SCN;
                end
            end
            ST_DONE_SCN: begin
                scn_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// tb/tb_sdram_client_arbiter.sv - directed self-checking bench for sdram_client_arbiter
module tb_sdram_client_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cpu_addr;
    logic [15:0] cpu_data;
    logic [1:0]  cpu_be;
    logic        cpu_rw;
    logic        cpu_req;
    logic        cpu_ack;
    logic [15:0] cpu_q;
    logic [31:0] scn_addr;
    logic        scn_req;
    logic        scn_ack;
    logic [31:0] scn_q;
    logic        ram_cmd;
    logic        ram_cmd_rdy;
    logic [24:0] ram_addr;
    logic        ram_we;
    logic        ram_burst2;
    logic [1:0]  ram_be;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_rvalid;
    logic        ram_wdone;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sdram_client_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_be      (cpu_be),
        .cpu_rw      (cpu_rw),
        .cpu_req     (cpu_req),
        .cpu_ack     (cpu_ack),
        .cpu_q       (cpu_q),
        .scn_addr    (scn_addr),
        .scn_req     (scn_req),
        .scn_ack     (scn_ack),
        .scn_q       (scn_q),
        .ram_cmd     (ram_cmd),
        .ram_cmd_rdy (ram_cmd_rdy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_burst2  (ram_burst2),
        .ram_be      (ram_be),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_rvalid  (ram_rvalid),
        .ram_wdone   (ram_wdone)
    );

    // Bounded wait for a command to appear; returns at a negedge.
    task automatic wait_cmd(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ram_cmd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Bounded wait until the chosen channel is no longer pending.
    task automatic wait_ack(input bit is_scn, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (is_scn ? (scn_ack === scn_req) : (cpu_ack === cpu_req)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Controller response to an accepted read: one word, or two for a burst.
    task automatic give_words(input bit two, input logic [15:0] w0, input logic [15:0] w1);
        @(negedge clk);
        ram_rvalid = 1'b1;
        ram_rdata  = w0;
        @(negedge clk);
        ram_rvalid = 1'b0;
        if (two) begin
            @(negedge clk);
            ram_rvalid = 1'b1;
            ram_rdata  = w1;
            @(negedge clk);
            ram_rvalid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        compared++;
        if (ram_cmd !== 1'b0) begin mismatched++; $display("FAIL reset_ram_cmd got %0b want 0", ram_cmd); end
        compared++;
        if (cpu_ack !== 1'b0 || scn_ack !== 1'b0) begin mismatched++; $display("FAIL reset_acks got %0b%0b want 00", cpu_ack, scn_ack); end
        compared++;
        if (cpu_q !== 16'h0 || scn_q !== 32'h0) begin mismatched++; $display("FAIL reset_q got %h %h want 0 0", cpu_q, scn_q); end
        compared++;
        if (ram_addr !== 25'h0 || ram_we !== 1'b0 || ram_burst2 !== 1'b0 || ram_be !== 2'b00 || ram_wdata !== 16'h0) begin
            mismatched++; $display("FAIL reset_fields got addr %h we %0b b2 %0b be %b wd %h want all 0", ram_addr, ram_we, ram_burst2, ram_be, ram_wdata);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (ram_cmd !== 1'b0) begin mismatched++; $display("FAIL idle_no_cmd got %0b want 0", ram_cmd); end
    endtask

    task automatic test_cpu_read();
        bit seen, ok;
        cpu_addr = 32'h0000_0124;
        cpu_rw   = 1'b1;
        cpu_be   = 2'b00;
        cpu_req  = ~cpu_req;
        wait_cmd(seen);
        compared++;
        if (!seen) begin mismatched++; $display("FAIL rd_cmd_timeout got no ram_cmd want ram_cmd=1"); end
        compared++;
        if (ram_addr !== 25'h92 || ram_we !== 1'b0 || ram_be !== 2'b11 || ram_burst2 !== 1'b0) begin
            mismatched++; $display("FAIL rd_fields got addr %h we %0b be %b b2 %0b want 92 0 11 0", ram_addr, ram_we, ram_be, ram_burst2);
        end
        repeat (3) @(negedge clk);
        ram_rvalid = 1'b1;
        ram_rdata  = 16'hBEEF;
        @(negedge clk);
        ram_rvalid = 1'b0;
        compared++;
        if (cpu_q !== 16'hBEEF) begin mismatched++; $display("FAIL rd_q_early got %h want BEEF", cpu_q); end
        compared++;
        if (cpu_ack === cpu_req) begin mismatched++; $display("FAIL rd_ack_early got ack %0b want still pending", cpu_ack); end
        @(negedge clk);
        compared++;
        if (cpu_ack !== cpu_req) begin mismatched++; $display("FAIL rd_ack got %0b want %0b", cpu_ack, cpu_req); end
        repeat (5) @(negedge clk);
        compared++;
        if (cpu_ack !== cpu_req || ram_cmd !== 1'b0) begin mismatched++; $display("FAIL rd_ack_once got ack %0b cmd %0b want %0b 0", cpu_ack, ram_cmd, cpu_req); end
    endtask

    task automatic test_cpu_write();
        bit seen, ok;
        cpu_addr = 32'h0010_0002;
        cpu_rw   = 1'b0;
        cpu_be   = 2'b01;
        cpu_data = 16'h1234;
        cpu_req  = ~cpu_req;
        wait_cmd(seen);
        compared++;
        if (!seen) begin mismatched++; $display("FAIL wr_cmd_timeout got no ram_cmd want ram_cmd=1"); end
        compared++;
        if (ram_addr !== 25'h80001 || ram_we !== 1'b1 || ram_be !== 2'b01 || ram_wdata !== 16'h1234 || ram_burst2 !== 1'b0) begin
            mismatched++; $display("FAIL wr_fields got addr %h we %0b be %b wd %h b2 %0b want 80001 1 01 1234 0", ram_addr, ram_we, ram_be, ram_wdata, ram_burst2);
        end
        @(negedge clk);
        // A stray read strobe must not complete a write.
        ram_rvalid = 1'b1;
        ram_rdata  = 16'h5555;
        @(negedge clk);
        ram_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (cpu_ack === cpu_req) begin mismatched++; $display("FAIL wr_ack_before_wdone got ack %0b want pending", cpu_ack); end
        ram_wdone = 1'b1;
        @(negedge clk);
        ram_wdone = 1'b0;
        wait_ack(1'b0, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL wr_ack got %0b want %0b", cpu_ack, cpu_req); end
        compared++;
        if (cpu_q !== 16'hBEEF) begin mismatched++; $display("FAIL wr_q_held got %h want BEEF", cpu_q); end
    endtask

    task automatic test_scn_read();
        bit seen, ok;
        scn_addr = 32'h0000_0010;
        scn_req  = ~scn_req;
        wait_cmd(seen);
        compared++;
        if (!seen) begin mismatched++; $display("FAIL scn_cmd_timeout got no ram_cmd want ram_cmd=1"); end
        compared++;
        if (ram_addr !== 25'h200008 || ram_burst2 !== 1'b1 || ram_we !== 1'b0) begin
            mismatched++; $display("FAIL scn_fields got addr %h b2 %0b we %0b want 200008 1 0", ram_addr, ram_burst2, ram_we);
        end
        give_words(1'b1, 16'h1111, 16'h2222);
        wait_ack(1'b1, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL scn_ack got %0b want %0b", scn_ack, scn_req); end
        compared++;
        if (scn_q !== 32'h1111_2222) begin mismatched++; $display("FAIL scn_q got %h want 11112222", scn_q); end
        compared++;
        if (cpu_ack !== cpu_req) begin mismatched++; $display("FAIL scn_cpu_untouched got %0b want %0b", cpu_ack, cpu_req); end
    endtask

    task automatic test_back_to_back();
        bit seen, ok, want_scn;
        cpu_addr = 32'h0000_0200;
        cpu_rw   = 1'b1;
        scn_addr = 32'h0000_0040;
        cpu_req  = ~cpu_req;
        scn_req  = ~scn_req;
        for (int k = 0; k < 8; k++) begin
            want_scn = k[0];
            wait_cmd(seen);
            compared++;
            if (!seen || ram_burst2 !== want_scn) begin
                mismatched++; $display("FAIL alt_grant_%0d got cmd %0b burst2 %0b want 1 %0b", k, seen, ram_burst2, want_scn);
            end
            give_words(want_scn, 16'(16'hA000 + k), 16'(16'hB000 + k));
            wait_ack(want_scn, ok);
            if (!ok) begin
                compared++; mismatched++; $display("FAIL alt_ack_%0d got no ack want ack", k);
            end
            if (k + 2 < 8) begin
                if (want_scn) scn_req = ~scn_req;
                else          cpu_req = ~cpu_req;
            end
        end
        compared++;
        if (cpu_q !== 16'hA006 || scn_q !== 32'hA007_B007) begin
            mismatched++; $display("FAIL alt_last_q got %h %h want A006 A007B007", cpu_q, scn_q);
        end
    endtask

    task automatic test_cmd_stall();
        bit seen, ok, bad;
        ram_cmd_rdy = 1'b0;
        cpu_addr = 32'h0000_2468;
        cpu_rw   = 1'b1;
        cpu_req  = ~cpu_req;
        wait_cmd(seen);
        compared++;
        if (!seen) begin mismatched++; $display("FAIL stall_cmd_timeout got no ram_cmd want ram_cmd=1"); end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ram_rvalid = (i == 2);
            ram_rdata  = 16'hDEAD;
            @(negedge clk);
            if (ram_cmd !== 1'b1 || ram_addr !== 25'h1234 || ram_we !== 1'b0 || cpu_ack === cpu_req) bad = 1'b1;
        end
        ram_rvalid = 1'b0;
        compared++;
        if (bad) begin mismatched++; $display("FAIL stall_hold got cmd %0b addr %h ack %0b want 1 1234 pending", ram_cmd, ram_addr, cpu_ack); end
        ram_cmd_rdy = 1'b1;
        give_words(1'b0, 16'hC0DE, 16'h0000);
        wait_ack(1'b0, ok);
        compared++;
        if (!ok || cpu_q !== 16'hC0DE) begin mismatched++; $display("FAIL stall_done got ok %0b q %h want 1 C0DE", ok, cpu_q); end
    endtask

    task automatic test_reset_mid_burst();
        bit seen, ok;
        scn_addr = 32'h0000_0100;
        scn_req  = ~scn_req;
        wait_cmd(seen);
        @(negedge clk);
        ram_rvalid = 1'b1;
        ram_rdata  = 16'h7777;
        #1;
        reset_n = 1'b0;
        #1;
        compared++;
        if (scn_ack !== 1'b0 || cpu_ack !== 1'b0 || scn_q !== 32'h0 || cpu_q !== 16'h0) begin
            mismatched++; $display("FAIL mid_reset_chan got acks %0b%0b q %h %h want 00 0 0", cpu_ack, scn_ack, cpu_q, scn_q);
        end
        compared++;
        if (ram_cmd !== 1'b0 || ram_addr !== 25'h0 || ram_burst2 !== 1'b0) begin
            mismatched++; $display("FAIL mid_reset_ram got cmd %0b addr %h b2 %0b want 0 0 0", ram_cmd, ram_addr, ram_burst2);
        end
        ram_rvalid = 1'b0;
        scn_req  = 1'b1;
        cpu_req  = 1'b0;
        scn_addr = 32'h0000_0008;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_cmd(seen);
        compared++;
        if (!seen || ram_addr !== 25'h200004 || ram_burst2 !== 1'b1) begin
            mismatched++; $display("FAIL post_reset_cmd got cmd %0b addr %h b2 %0b want 1 200004 1", seen, ram_addr, ram_burst2);
        end
        give_words(1'b1, 16'h3333, 16'h4444);
        wait_ack(1'b1, ok);
        compared++;
        if (!ok || scn_ack !== 1'b1 || scn_q !== 32'h3333_4444) begin
            mismatched++; $display("FAIL post_reset_done got ack %0b q %h want 1 33334444", scn_ack, scn_q);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        cpu_addr    = 32'h0;
        cpu_data    = 16'h0;
        cpu_be      = 2'b00;
        cpu_rw      = 1'b1;
        cpu_req     = 1'b0;
        scn_addr    = 32'h0;
        scn_req     = 1'b0;
        ram_cmd_rdy = 1'b1;
        ram_rdata   = 16'h0;
        ram_rvalid  = 1'b0;
        ram_wdone   = 1'b0;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_scn_read();
        test_back_to_back();
        test_cmd_stall();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
